frame_sequencer: RTL and testbench

Parametrised frame-loop controller for the VGA game: it sequences reset, coordinate load, per-object draw, collision check, frame wait and per-object erase for a player plus up to NUM_OBJ-1 enemies. It is the generalised successor to the fixed player+one-enemy game FSM. It drives the shared drawing datapath through an object select and pixel index, and adds per-object enables, masked collision, pause and restart-from-game-over.

---
 rtl/frame_sequencer.sv | 132 +++++++++++++
 tb/tb_frame_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: frame-loop controller sequencing reset, load, draw, check, wait and erase over NUM_OBJ objects
module frame_sequencer #(
  parameter int NUM_OBJ      = 4,
  parameter int OBJ_W        = 2,
  parameter int SELF_PIXELS  = 25,
  parameter int ENEMY_PIXELS = 250,
  parameter int PIX_W        = 8,
  parameter int WAIT_CYCLES  = 1666666,
  parameter int WAIT_W       = 21
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               pause,
  input  logic [NUM_OBJ-1:0] obj_enable,
  input  logic [NUM_OBJ-1:0] collide,
  output logic               move_en,
  output logic               load_coord,
  output logic               plot,
  output logic               erase,
  output logic               reset_n_out,
  output logic [OBJ_W-1:0]   obj_sel,
  output logic [PIX_W-1:0]   pix_idx,
  output logic               frame_tick,
  output logic               game_over,
  output logic [3:0]         state
);
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    START_WAIT = 4'd1,
    RESET      = 4'd2,
    LOAD       = 4'd3,
    DRAW       = 4'd4,
    CHECK      = 4'd5,
    WAIT       = 4'd6,
    ERASE      = 4'd7,
    OVER       = 4'd8
  } state_t;

  localparam logic [PIX_W-1:0]  SELF_LAST  = PIX_W'(SELF_PIXELS - 1);
  localparam logic [PIX_W-1:0]  ENEMY_LAST = PIX_W'(ENEMY_PIXELS - 1);
  localparam logic [OBJ_W-1:0]  LAST_OBJ   = OBJ_W'(NUM_OBJ - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [OBJ_W-1:0]  obj_q, obj_d, obj_nxt;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              obj_done, last_obj, go;

  // en_q holds the enable of the object being scanned; it is captured on the edge that starts that object
  assign obj_nxt  = obj_q + 1'b1;
  assign obj_done = !en_q || pix_q == (obj_q == '0 ? SELF_LAST : ENEMY_LAST);
  assign last_obj = obj_q == LAST_OBJ;
  assign go       = state_q == WAIT && cnt_q == WAIT_LAST && !pause;

  // next-state, object/pixel scan and frame-wait counter
  always_comb begin
    state_d = state_q;
    obj_d   = obj_q;
    pix_d   = pix_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:       if (start) state_d = START_WAIT;
      START_WAIT: if (!start) state_d = RESET;
      RESET:      state_d = LOAD;
      LOAD: begin
        state_d = DRAW;
        obj_d   = '0;
        pix_d   = '0;
        en_d    = obj_enable[0];
      end
      DRAW, ERASE: begin
        if (!obj_done) pix_d = pix_q + 1'b1;
        else if (!last_obj) begin
          obj_d = obj_nxt;
          pix_d = '0;
          en_d  = obj_enable[obj_nxt];
        end else begin
          state_d = state_q == DRAW ? CHECK : LOAD;
          obj_d   = '0;
          pix_d   = '0;
          en_d    = 1'b0;
        end
      end
      CHECK: begin
        state_d = |(collide & obj_enable) ? OVER : WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (go) begin
          state_d = ERASE;
          obj_d   = '0;
          pix_d   = '0;
          en_d    = obj_enable[0];
        end else if (!pause) cnt_d = cnt_q + 1'b1;
      end
      OVER:       if (start) state_d = START_WAIT;
      default:    state_d = IDLE;
    endcase
  end

  // state and counter registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      obj_q   <= '0;
      pix_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      obj_q   <= obj_d;
      pix_q   <= pix_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

  assign state       = state_q;
  assign move_en     = state_q == DRAW || state_q == WAIT || state_q == ERASE;
  assign load_coord  = state_q == LOAD;
  assign plot        = (state_q == DRAW || state_q == ERASE) && en_q;
  assign erase       = state_q == ERASE;
  assign reset_n_out = state_q != RESET;
  assign game_over   = state_q == OVER;
  assign obj_sel     = obj_q;
  assign pix_idx     = pix_q;
  assign frame_tick  = go;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: scoreboard bench comparing the per-cycle output trace against expected frames
module tb_frame_sequencer;
  localparam int NO = 3, OW = 2, SP = 4, EP = 6, PW = 8, WC = 5, WW = 3;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, pause = 1'b0;
  logic [NO-1:0] obj_enable = '1, collide = '0;
  logic          move_en, load_coord, plot, erase, reset_n_out, frame_tick, game_over;
  logic [OW-1:0] obj_sel;
  logic [PW-1:0] pix_idx;
  logic [3:0]    state;
  int            n_chk = 0, n_bad = 0;
  string         ph = "reset";
  logic [20:0]   exp_q[$];

  always #5 clk = ~clk;

  frame_sequencer #(
    .NUM_OBJ(NO), .OBJ_W(OW), .SELF_PIXELS(SP), .ENEMY_PIXELS(EP),
    .PIX_W(PW), .WAIT_CYCLES(WC), .WAIT_W(WW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause),
    .obj_enable(obj_enable), .collide(collide), .move_en(move_en),
    .load_coord(load_coord), .plot(plot), .erase(erase),
    .reset_n_out(reset_n_out), .obj_sel(obj_sel), .pix_idx(pix_idx),
    .frame_tick(frame_tick), .game_over(game_over), .state(state)
  );

  // expected output word for a state, with outputs that follow from the state code alone filled in
  function automatic logic [20:0] ew(int st, int o = 0, int p = 0, bit pl = 0, bit ft = 0);
    logic [3:0] s;
    s = 4'(st);
    return {s, st == 4 || st == 6 || st == 7, st == 3, pl, st == 7, st != 2, ft, st == 8, 2'(o), 8'(p)};
  endfunction

  function automatic logic [20:0] obs();
    return {state, move_en, load_coord, plot, erase, reset_n_out, frame_tick, game_over, obj_sel, pix_idx};
  endfunction

  task automatic check(string tag, logic [20:0] got, logic [20:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic cyc();
    #1;
    if (exp_q.size() > 0) check(ph, obs(), exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) cyc();
  endtask

  task automatic push_scan(int st, logic [NO-1:0] en);
    for (int o = 0; o < NO; o++)
      if (en[o]) for (int p = 0; p < (o == 0 ? SP : EP); p++) exp_q.push_back(ew(st, o, p, 1));
      else exp_q.push_back(ew(st, o));
  endtask

  task automatic push_wait(int n);
    for (int i = 1; i <= n; i++) exp_q.push_back(ew(6, 0, 0, 0, i == n));
  endtask

  initial begin
    #12;
    check("reset_vals", obs(), ew(0));
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;
    ph = "nominal";
    start = 1'b1;
    exp_q.push_back(ew(0));
    exp_q.push_back(ew(1));
    drain();
    start = 1'b0;
    exp_q.push_back(ew(1));
    exp_q.push_back(ew(2));
    exp_q.push_back(ew(3));
    push_scan(4, 3'b111);
    exp_q.push_back(ew(5));
    push_wait(WC);
    push_scan(7, 3'b111);
    drain();
    ph = "disabled_obj";
    obj_enable = 3'b101;
    collide = 3'b111;
    exp_q.push_back(ew(3));
    push_scan(4, 3'b101);
    drain();
    ph = "collide_masked";
    collide = 3'b010;
    exp_q.push_back(ew(5));
    drain();
    ph = "pause";
    push_wait(8);
    for (int i = 1; i <= 8; i++) begin
      pause = i >= 3 && i <= 5;
      cyc();
    end
    pause = 1'b0;
    ph = "erase_101";
    push_scan(7, 3'b101);
    drain();
    ph = "all_disabled";
    obj_enable = 3'b000;
    collide = 3'b111;
    exp_q.push_back(ew(3));
    push_scan(4, 3'b000);
    exp_q.push_back(ew(5));
    drain();
    ph = "pause_on_go";
    push_wait(6);
    for (int i = 1; i <= 6; i++) begin
      pause = i == 5;
      cyc();
    end
    pause = 1'b0;
    push_scan(7, 3'b000);
    drain();
    ph = "collide_over";
    obj_enable = 3'b111;
    collide = 3'b000;
    exp_q.push_back(ew(3));
    push_scan(4, 3'b111);
    drain();
    collide = 3'b010;
    repeat (4) exp_q.push_back(ew(8));
    exp_q.push_back(ew(5));
    exp_q.pop_back();
    exp_q.push_front(ew(5));
    drain();
    ph = "restart";
    start = 1'b1;
    exp_q.push_back(ew(8));
    exp_q.push_back(ew(1));
    exp_q.push_back(ew(1));
    drain();
    start = 1'b0;
    exp_q.push_back(ew(1));
    exp_q.push_back(ew(2));
    exp_q.push_back(ew(3));
    exp_q.push_back(ew(4, 0, 0, 1));
    exp_q.push_back(ew(4, 0, 1, 1));
    drain();
    #1;
    check("draw_pix2", obs(), ew(4, 0, 2, 1));
    #1 reset_n = 1'b0;
    #1;
    check("async_rst", obs(), ew(0));
    #10;
    check("rst_hold", obs(), ew(0));
    start = 1'b1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("resume_idle", obs(), ew(1));
    ph = "after_reset";
    start = 1'b0;
    exp_q.push_back(ew(1));
    exp_q.push_back(ew(2));
    exp_q.push_back(ew(3));
    drain();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
